rs_dec_corr_out: RTL and testbench

- Parametrised output/correction stage of the RS decoder; successor to the fixed fifo_buffer + dec_ctrl + err_correct path.
- Buffers up to FRM_DEPTH received codewords of variable (shortened) length, each up to N_MAX symbols.
- Pairs each codeword with its error list from err_value in frame order, XOR-corrects the listed positions, and emits framed output with sop/eop, a fail flag, optional parity stripping and valid/ready backpressure.

---
 rtl/rs_dec_corr_out.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_rs_dec_corr_out.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dec_corr_out.sv
// RS decoder output stage: frame buffer, FIFO pairing with error lists,
// XOR correction and framed valid/ready output with optional parity strip.
module rs_dec_corr_out #(
   parameter int SYM_BW       = 8,
   parameter int N_MAX        = 255,
   parameter int R_NUM        = 16,
   parameter int T_NUM        = 8,
   parameter int FRM_DEPTH    = 4,
   parameter int STRIP_PARITY = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       din_val,
   input  logic                       din_sop,
   input  logic                       din_eop,
   input  logic [SYM_BW-1:0]          din,
   input  logic                       corr_val,
   input  logic [$clog2(T_NUM+1)-1:0] err_num,
   input  logic [SYM_BW*T_NUM-1:0]    err_loc,
   input  logic [SYM_BW*T_NUM-1:0]    err_val,
   input  logic                       dec_fail,
   input  logic                       dout_rdy,
   output logic                       dout_val,
   output logic                       dout_sop,
   output logic                       dout_eop,
   output logic [SYM_BW-1:0]          dout,
   output logic                       dout_fail,
   output logic                       ovf
);

   localparam int ENW     = $clog2(T_NUM+1);
   localparam int LW      = $clog2(N_MAX+1);
   localparam int PW      = $clog2(FRM_DEPTH);
   localparam int CW      = PW + 1;
   localparam int DEPTH   = FRM_DEPTH * N_MAX;
   localparam int AW      = $clog2(DEPTH);
   localparam int STRIP_N = (STRIP_PARITY != 0) ? R_NUM : 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

   logic [SYM_BW-1:0]       r_ram [DEPTH];
   logic [SYM_BW-1:0]       r_rdata;

   logic [LW-1:0]           r_lq [FRM_DEPTH];
   logic [PW-1:0]           r_lq_wp;
   logic [PW-1:0]           r_lq_rp;
   logic [CW-1:0]           r_lq_cnt;
   logic                    r_open;
   logic [LW-1:0]           r_widx;

   logic [ENW-1:0]          r_cq_num  [FRM_DEPTH];
   logic [SYM_BW*T_NUM-1:0] r_cq_loc  [FRM_DEPTH];
   logic [SYM_BW*T_NUM-1:0] r_cq_val  [FRM_DEPTH];
   logic                    r_cq_fail [FRM_DEPTH];
   logic [PW-1:0]           r_cq_wp;
   logic [PW-1:0]           r_cq_rp;
   logic [CW-1:0]           r_cq_cnt;

   state_t                  r_state;
   logic [LW-1:0]           r_emit;
   logic [ENW-1:0]          r_enum;
   logic [SYM_BW*T_NUM-1:0] r_eloc;
   logic [SYM_BW*T_NUM-1:0] r_evl;
   logic                    r_fail;
   logic [PW-1:0]           r_rslot;
   logic [LW-1:0]           r_pidx;
   logic                    r_pval;

   logic                    r_dval;
   logic                    r_sop;
   logic                    r_eop;
   logic [SYM_BW-1:0]       r_dout;
   logic                    r_dfail;
   logic                    r_ovf;

   logic                    w_lq_full;
   logic                    w_cq_full;
   logic                    w_we;
   logic                    w_push;
   logic [LW-1:0]           w_widx;
   logic [AW-1:0]           w_waddr;
   logic                    w_cpush;
   logic [ENW-1:0]          w_cnum;
   logic                    w_ready;
   logic                    w_pop;
   logic [LW:0]             w_emit;
   logic                    w_emit_bad;
   logic                    w_adv;
   logic                    w_last;
   logic                    w_re;
   logic [AW-1:0]           w_raddr;
   logic [SYM_BW-1:0]       w_corr;

   // The slot being emitted stays reserved until its last read is issued.
   assign w_lq_full = (32'(r_lq_cnt) + ((r_state == S_RUN) ? 1 : 0))
                      >= FRM_DEPTH;
   assign w_cq_full = (r_cq_cnt == CW'(FRM_DEPTH));
   assign w_cpush   = corr_val & ~w_cq_full;
   assign w_cnum    = (32'(err_num) > T_NUM) ? ENW'(T_NUM) : err_num;
   assign w_ready   = (r_lq_cnt != '0) & ((r_cq_cnt != '0) | corr_val);
   assign w_pop     = (r_state == S_LOAD);
   assign w_emit    = {1'b0, r_lq[r_lq_rp]} - (LW+1)'(STRIP_N);
   assign w_emit_bad = w_emit[LW] | (w_emit == '0);
   assign w_adv     = ~r_dval | dout_rdy;
   assign w_last    = (r_pidx == r_emit - LW'(1));
   assign w_waddr   = AW'(r_lq_wp) * AW'(N_MAX) + AW'(w_widx);

   always_comb begin
      w_we   = 1'b0;
      w_push = 1'b0;
      w_widx = '0;
      if (din_val) begin
         if (din_sop) begin
            w_we   = ~w_lq_full;
            w_push = ~w_lq_full & din_eop;
         end else if (r_open && r_widx != LW'(N_MAX)) begin
            w_we   = 1'b1;
            w_widx = r_widx;
            w_push = din_eop;
         end
      end
   end

   always_comb begin
      w_re    = 1'b0;
      w_raddr = '0;
      unique case (1'b1)
         (r_state == S_LOAD): begin
            w_re    = 1'b1;
            w_raddr = AW'(r_lq_rp) * AW'(N_MAX);
         end
         (r_state == S_RUN && w_adv && r_pval && !w_last): begin
            w_re    = 1'b1;
            w_raddr = AW'(r_rslot) * AW'(N_MAX) + AW'(r_pidx) + AW'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_corr = '0;
      for (int i = 0; i < T_NUM; i++) begin
         if (i < int'(r_enum) &&
             32'(r_eloc[i*SYM_BW +: SYM_BW]) == 32'(r_pidx))
            w_corr = w_corr ^ r_evl[i*SYM_BW +: SYM_BW];
      end
   end

   always_ff @(posedge clk) begin
      if (w_we)
         r_ram[w_waddr] <= din;
      if (w_re)
         r_rdata <= r_ram[w_raddr];
      if (w_push)
         r_lq[r_lq_wp] <= w_widx + LW'(1);
      if (w_cpush) begin
         r_cq_num[r_cq_wp]  <= w_cnum;
         r_cq_loc[r_cq_wp]  <= err_loc;
         r_cq_val[r_cq_wp]  <= err_val;
         r_cq_fail[r_cq_wp] <= dec_fail;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lq_wp  <= '0;
         r_lq_rp  <= '0;
         r_lq_cnt <= '0;
         r_open   <= 1'b0;
         r_widx   <= '0;
         r_cq_wp  <= '0;
         r_cq_rp  <= '0;
         r_cq_cnt <= '0;
         r_state  <= S_IDLE;
         r_emit   <= '0;
         r_enum   <= '0;
         r_eloc   <= '0;
         r_evl    <= '0;
         r_fail   <= 1'b0;
         r_rslot  <= '0;
         r_pidx   <= '0;
         r_pval   <= 1'b0;
         r_dval   <= 1'b0;
         r_sop    <= 1'b0;
         r_eop    <= 1'b0;
         r_dout   <= '0;
         r_dfail  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (din_val) begin
            if (din_sop) begin
               if (w_lq_full) begin
                  r_open <= 1'b0;
                  r_ovf  <= 1'b1;
               end else begin
                  r_open <= ~din_eop;
                  r_widx <= LW'(1);
               end
            end else if (r_open) begin
               if (r_widx == LW'(N_MAX)) begin
                  r_open <= 1'b0;
                  r_ovf  <= 1'b1;
               end else if (din_eop) begin
                  r_open <= 1'b0;
               end else begin
                  r_widx <= r_widx + LW'(1);
               end
            end
         end
         if (w_push)
            r_lq_wp <= r_lq_wp + PW'(1);
         r_lq_cnt <= r_lq_cnt + CW'(w_push) - CW'(w_pop);

         if (w_cpush)
            r_cq_wp <= r_cq_wp + PW'(1);
         if (corr_val && w_cq_full)
            r_ovf <= 1'b1;
         r_cq_cnt <= r_cq_cnt + CW'(w_cpush) - CW'(w_pop);

         unique case (r_state)
            S_IDLE: begin
               if (w_ready)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_lq_rp <= r_lq_rp + PW'(1);
               r_cq_rp <= r_cq_rp + PW'(1);
               r_rslot <= r_lq_rp;
               r_emit  <= w_emit[LW-1:0];
               r_enum  <= r_cq_num[r_cq_rp];
               r_eloc  <= r_cq_loc[r_cq_rp];
               r_evl   <= r_cq_val[r_cq_rp];
               r_fail  <= r_cq_fail[r_cq_rp];
               if (w_emit_bad) begin
                  r_ovf   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_pidx  <= '0;
                  r_pval  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_adv) begin
                  if (r_pval) begin
                     r_dval  <= 1'b1;
                     r_dout  <= r_rdata ^ (r_fail ? '0 : w_corr);
                     r_sop   <= (r_pidx == '0);
                     r_eop   <= w_last;
                     r_dfail <= r_fail;
                     if (w_last)
                        r_pval <= 1'b0;
                     else
                        r_pidx <= r_pidx + LW'(1);
                  end else begin
                     // eop has just been accepted downstream
                     r_dval  <= 1'b0;
                     r_sop   <= 1'b0;
                     r_eop   <= 1'b0;
                     r_dfail <= 1'b0;
                     r_state <= w_ready ? S_LOAD : S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dout_val  = r_dval;
   assign dout_sop  = r_sop;
   assign dout_eop  = r_eop;
   assign dout      = r_dout;
   assign dout_fail = r_dfail;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_rs_dec_corr_out.sv
// Directed bench for rs_dec_corr_out: one instance keeps parity,
// a second strips it; both see the same input stimulus.
module tb_rs_dec_corr_out;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        din_val, din_sop, din_eop;
   logic [7:0]  din;
   logic        corr_val;
   logic [3:0]  err_num;
   logic [63:0] err_loc, err_val;
   logic        dec_fail;
   logic        dout_rdy;
   logic        s_rdy;
   logic        dout_val, dout_sop, dout_eop, dout_fail, ovf;
   logic [7:0]  dout;
   logic        s_val, s_sop, s_eop, s_fail, s_ovf;
   logic [7:0]  s_dout;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          t_corr;
   logic [10:0] q_m[$];
   logic [10:0] q_s[$];

   int          g_first, g_n, g_l0, g_v0, g_l1, g_v1;
   bit          g_fail;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rs_dec_corr_out u_dut (
      .clk(clk), .rst_n(rst_n),
      .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop),
      .din(din), .corr_val(corr_val), .err_num(err_num),
      .err_loc(err_loc), .err_val(err_val), .dec_fail(dec_fail),
      .dout_rdy(dout_rdy), .dout_val(dout_val), .dout_sop(dout_sop),
      .dout_eop(dout_eop), .dout(dout), .dout_fail(dout_fail),
      .ovf(ovf)
   );

   rs_dec_corr_out #(.STRIP_PARITY(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n),
      .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop),
      .din(din), .corr_val(corr_val), .err_num(err_num),
      .err_loc(err_loc), .err_val(err_val), .dec_fail(dec_fail),
      .dout_rdy(s_rdy), .dout_val(s_val), .dout_sop(s_sop),
      .dout_eop(s_eop), .dout(s_dout), .dout_fail(s_fail),
      .ovf(s_ovf)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_val && dout_rdy)
            q_m.push_back({dout_fail, dout_sop, dout_eop, dout});
         if (s_val && s_rdy)
            q_s.push_back({s_fail, s_sop, s_eop, s_dout});
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] expw(input int j, input int emit);
      logic [7:0] s;
      s = 8'(g_first + j);
      if (!g_fail) begin
         if (g_n >= 1 && g_l0 == j) s ^= 8'(g_v0);
         if (g_n >= 2 && g_l1 == j) s ^= 8'(g_v1);
      end
      return {g_fail, j == 0, j == emit - 1, s};
   endfunction

   task automatic set_g(input int first, input int n, input int l0,
                        input int v0, input int l1, input int v1,
                        input bit fail);
      g_first = first; g_n = n; g_fail = fail;
      g_l0 = l0; g_v0 = v0; g_l1 = l1; g_v1 = v1;
   endtask

   task automatic send_frame(input int len);
      for (int i = 0; i < len; i++) begin
         din_val = 1'b1;
         din_sop = (i == 0);
         din_eop = (i == len - 1);
         din     = 8'(g_first + i);
         @(posedge clk); #1;
      end
      din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
   endtask

   task automatic send_corr();
      corr_val = 1'b1;
      err_num  = 4'(g_n);
      err_loc  = {48'h0, 8'(g_l1), 8'(g_l0)};
      err_val  = {48'h0, 8'(g_v1), 8'(g_v0)};
      dec_fail = g_fail;
      t_corr   = cyc;
      @(posedge clk); #1;
      corr_val = 1'b0; dec_fail = 1'b0; err_num = '0;
   endtask

   task automatic wait_q(input int nm, input int ns, input string tag);
      for (int k = 0; k < 3000; k++) begin
         if (q_m.size() >= nm && q_s.size() >= ns) break;
         @(posedge clk); #1;
      end
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk(tag, 64'(q_m.size() >= nm && q_s.size() >= ns), 64'(1));
   endtask

   task automatic chk_stream(input bit strip, input int emit,
                             input string tag);
      for (int j = 0; j < emit; j++) begin
         logic [10:0] w;
         w = 'x;
         if (strip) begin
            if (q_s.size() > 0) w = q_s.pop_front();
         end else begin
            if (q_m.size() > 0) w = q_m.pop_front();
         end
         chk($sformatf("%s[%0d]", tag, j), 64'(w), 64'(expw(j, emit)));
      end
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_m_left"}, 64'(q_m.size()), 64'(0));
      chk({tag, "_s_left"}, 64'(q_s.size()), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      din_val = 0; din_sop = 0; din_eop = 0; din = '0;
      corr_val = 0; err_num = '0; err_loc = '0; err_val = '0;
      dec_fail = 0; dout_rdy = 1; s_rdy = 1;
      set_g(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_val", 64'(dout_val), 64'(0));
      chk("rst_sop", 64'(dout_sop), 64'(0));
      chk("rst_eop", 64'(dout_eop), 64'(0));
      chk("rst_dout", 64'(dout), 64'(0));
      chk("rst_fail", 64'(dout_fail), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // full-length frame, no errors, latency
      set_g(0, 0, 0, 0, 0, 0, 0);
      send_frame(255);
      send_corr();
      for (int k = 0; k < 20; k++) begin
         if (dout_val) break;
         @(posedge clk); #1;
      end
      chk("t1_lat", 64'(cyc - t_corr), 64'(3));
      wait_q(255, 239, "t1_wait");
      chk_stream(0, 255, "t1m");
      chk_stream(1, 239, "t1s");
      chk_empty("t1");

      // two corrections
      set_g(0, 2, 3, 8'h5A, 200, 8'h01, 0);
      send_frame(255);
      send_corr();
      wait_q(255, 239, "t2_wait");
      chk_stream(0, 255, "t2m");
      chk_stream(1, 239, "t2s");
      chk_empty("t2");

      // shortened frame, then same frame uncorrectable
      set_g(8'h10, 0, 0, 0, 0, 0, 0);
      send_frame(40);
      send_corr();
      wait_q(40, 24, "t3a_wait");
      chk_stream(0, 40, "t3am");
      chk_stream(1, 24, "t3as");
      chk_empty("t3a");
      set_g(8'h10, 2, 1, 8'h33, 5, 8'h44, 1);
      send_frame(40);
      send_corr();
      wait_q(40, 24, "t3b_wait");
      chk_stream(0, 40, "t3bm");
      chk_stream(1, 24, "t3bs");
      chk_empty("t3b");

      // backpressure 1-0-0-1 on the main instance
      set_g(5, 1, 100, 8'hFF, 0, 0, 0);
      send_frame(255);
      send_corr();
      for (int k = 0; k < 3000; k++) begin
         if (q_m.size() >= 255) break;
         if (dout_val)
            chk($sformatf("t4_hold[%0d]", q_m.size()),
                64'({dout_fail, dout_sop, dout_eop, dout}),
                64'(expw(q_m.size(), 255)));
         dout_rdy = (k % 4 == 0) || (k % 4 == 3);
         @(posedge clk); #1;
      end
      dout_rdy = 1'b1;
      wait_q(255, 239, "t4_wait");
      chk("t4_cnt", 64'(q_m.size()), 64'(255));
      chk_stream(0, 255, "t4m");
      chk_stream(1, 239, "t4s");
      chk_empty("t4");

      // five frames into four slots, then four corrections
      for (int f = 0; f < 5; f++) begin
         if (f == 4) chk("t5_ovf_pre", 64'(ovf), 64'(0));
         set_g(f * 40, 0, 0, 0, 0, 0, 0);
         send_frame(20);
      end
      chk("t5_ovf", 64'(ovf), 64'(1));
      chk("t5_ovf_s", 64'(s_ovf), 64'(1));
      set_g(0, 0, 0, 0, 0, 0, 0);
      repeat (4) send_corr();
      wait_q(80, 16, "t5_wait");
      for (int f = 0; f < 4; f++) begin
         set_g(f * 40, 0, 0, 0, 0, 0, 0);
         chk_stream(0, 20, $sformatf("t5m%0d", f));
         chk_stream(1, 4, $sformatf("t5s%0d", f));
      end
      chk_empty("t5");

      // reset in the middle of a frame
      set_g(8'h80, 0, 0, 0, 0, 0, 0);
      send_frame(255);
      send_corr();
      for (int k = 0; k < 200; k++) begin
         if (q_m.size() >= 20) break;
         @(posedge clk); #1;
      end
      chk("t6_run", 64'(q_m.size() >= 20), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("t6_val", 64'(dout_val), 64'(0));
      chk("t6_sop", 64'(dout_sop), 64'(0));
      chk("t6_dout", 64'(dout), 64'(0));
      chk("t6_ovf", 64'(ovf), 64'(0));
      chk("t6_ovf_s", 64'(s_ovf), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_m.delete();
      q_s.delete();
      @(posedge clk); #1;
      set_g(8'h77, 1, 9, 8'h0F, 0, 0, 0);
      send_frame(10);
      send_corr();
      wait_q(10, 0, "t6_wait");
      chk_stream(0, 10, "t6m");
      chk_empty("t6");
      chk("t6_ovf_post", 64'(ovf), 64'(0));
      chk("t6_short_s", 64'(s_ovf), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
